latch_bank_wr_ctrl: RTL and testbench

- Write sequencer for a bank of DEPTH x WIDTH active-low-reset, transparent-high latches (one enable E per row, shared D bus, per-row RN).
- Accepts write requests over a valid/ready handshake and drives the shared data bus and the per-row enables.
- Sequences each write as setup, then enable pulse, then hold, so the latch setup/hold windows around the E falling edge are met by construction.
- Also sequences a bank-wide clear by pulsing every row's RN low.

---
 rtl/latch_bank_wr_ctrl_if.sv | 31 +++
 rtl/latch_bank_wr_ctrl.sv | 161 ++++++++++++++++
 tb/tb_latch_bank_wr_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/latch_bank_wr_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : latch_bank_wr_ctrl_if
//  Description : Request/status bundle between a bus master and the latch
//                bank write sequencer.
//  Revision    : 1.0
// ============================================================================
interface latch_bank_wr_ctrl_if #(
  parameter int AW    = 3,
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_data;
  logic             clr_req;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output req_valid, req_addr, req_data, clr_req,
    input  req_ready, busy, done, err
  );

  modport slave (
    input  req_valid, req_addr, req_data, clr_req,
    output req_ready, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/latch_bank_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : latch_bank_wr_ctrl
//  Description : Setup / enable-pulse / hold write sequencer and bank-wide
//                clear for a bank of transparent-high latches.
//  Revision    : 1.0
// ============================================================================
module latch_bank_wr_ctrl #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 8,
  parameter int AW        = 3,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  wire                    CLK,
  input  wire                    RN,
  latch_bank_wr_ctrl_if.slave    bus,
  output logic [WIDTH-1:0]       lat_d,
  output logic [DEPTH-1:0]       lat_e,
  output logic [DEPTH-1:0]       lat_rn
);

  localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_C  = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t           state_q,    state_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [AW-1:0]    addr_q,     addr_d;
  logic [WIDTH-1:0] lat_d_q,    lat_d_d;
  logic [DEPTH-1:0] lat_e_q,    lat_e_d;
  logic [DEPTH-1:0] lat_rn_q,   lat_rn_d;
  logic             clr_pend_q, clr_pend_d;
  logic             done_q,     done_d;
  logic             err_q,      err_d;

  logic             w_in_range;
  logic [DEPTH-1:0] w_onehot;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      lat_d_q    <= '0;
      lat_e_q    <= '0;
      lat_rn_q   <= '1;
      clr_pend_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      lat_d_q    <= lat_d_d;
      lat_e_q    <= lat_e_d;
      lat_rn_q   <= lat_rn_d;
      clr_pend_q <= clr_pend_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    w_in_range = ({1'b0, addr_q} < DEPTH_W);
    w_onehot   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_onehot[i] = (addr_q == AW'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    lat_d_d    = lat_d_q;
    lat_e_d    = lat_e_q;
    lat_rn_d   = lat_rn_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    // A clear request arriving mid-sequence is remembered until IDLE.
    clr_pend_d = clr_pend_q | (bus.clr_req && (state_q != S_IDLE));

    unique case (state_q)
      S_IDLE: begin
        if (clr_pend_q || bus.clr_req) begin
          state_d  = S_CLEAR;
          cnt_d    = CW'(PULSE_CYC - 1);
          lat_rn_d = '0;
        end else if (bus.req_valid) begin
          state_d = S_SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
          addr_d  = bus.req_addr;
          lat_d_d = bus.req_data;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = CW'(PULSE_CYC - 1);
          lat_e_d = w_in_range ? w_onehot : '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
          lat_e_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = !w_in_range;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CLEAR: begin
        if (cnt_q == '0) begin
          state_d    = S_IDLE;
          lat_rn_d   = '1;
          done_d     = 1'b1;
          clr_pend_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        lat_e_d  = '0;
        lat_rn_d = '1;
      end
    endcase
  end

  assign bus.req_ready = (state_q == S_IDLE) && !clr_pend_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign lat_d         = lat_d_q;
  assign lat_e         = lat_e_q;
  assign lat_rn        = lat_rn_q;

endmodule
`default_nettype wire

// File: tb/tb_latch_bank_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_latch_bank_wr_ctrl
//  Description : Directed self-checking bench for latch_bank_wr_ctrl.
//  Revision    : 1.0
// ============================================================================
module tb_latch_bank_wr_ctrl;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int AW    = 4;

  logic             CLK;
  logic             RN;
  logic [WIDTH-1:0] lat_d;
  logic [DEPTH-1:0] lat_e;
  logic [DEPTH-1:0] lat_rn;

  int n_checks;
  int n_pass;

  latch_bank_wr_ctrl_if #(.AW(AW), .WIDTH(WIDTH)) bus ();

  latch_bank_wr_ctrl #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW),
    .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)
  ) dut (
    .CLK   (CLK),
    .RN    (RN),
    .bus   (bus.slave),
    .lat_d (lat_d),
    .lat_e (lat_e),
    .lat_rn(lat_rn)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RN = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.clr_req   = 1'b0;
    repeat (2) step();
    n_checks++;
    if ({lat_e, lat_rn, lat_d} !== {8'h00, 8'hFF, 8'h00})
      $display("FAIL reset_lat: e/rn/d=%h/%h/%h want 00/ff/00", lat_e, lat_rn, lat_d);
    else n_pass++;
    n_checks++;
    if ({bus.busy, bus.done, bus.err, bus.req_ready} !== 4'b0001)
      $display("FAIL reset_status: busy/done/err/ready=%b want 0001",
               {bus.busy, bus.done, bus.err, bus.req_ready});
    else n_pass++;
    RN = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    logic [7:0] exp_e [5];
    logic       exp_done [5];
    exp_e    = '{8'h00, 8'h08, 8'h08, 8'h00, 8'h00};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.req_valid = 1'b1; bus.req_addr = 4'd3; bus.req_data = 8'hA5;
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", bus.req_ready);
    else n_pass++;
    step();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (lat_e !== exp_e[k] || lat_d !== 8'hA5 || bus.done !== exp_done[k] || bus.err !== 1'b0)
        $display("FAIL single_c%0d: e=%h d=%h done=%b err=%b want e=%h d=a5 done=%b err=0",
                 k, lat_e, lat_d, bus.done, bus.err, exp_e[k], exp_done[k]);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_e [10];
    logic [7:0] exp_d [10];
    logic       exp_done [10];
    exp_e    = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h80, 8'h00, 8'h00};
    exp_d    = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.req_valid = 1'b1; bus.req_addr = 4'd0; bus.req_data = 8'h11;
    step();
    bus.req_addr = 4'd7; bus.req_data = 8'hEE;
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (lat_e !== exp_e[k] || lat_d !== exp_d[k] || bus.done !== exp_done[k])
        $display("FAIL b2b_c%0d: e=%h d=%h done=%b want e=%h d=%h done=%b",
                 k, lat_e, lat_d, bus.done, exp_e[k], exp_d[k], exp_done[k]);
      else n_pass++;
      if (k == 4) begin
        n_checks++;
        if (bus.req_ready !== 1'b1) $display("FAIL b2b_ready_done: got %b want 1", bus.req_ready);
        else n_pass++;
      end
      if (k == 5) bus.req_valid = 1'b0;
      step();
    end
  endtask

  task automatic test_clear_priority();
    logic [7:0] exp_rn [8];
    logic [7:0] exp_e  [8];
    logic [7:0] exp_d  [8];
    logic       exp_done [8];
    exp_rn   = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exp_e    = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h10, 8'h00, 8'h00};
    exp_d    = '{8'hEE, 8'hEE, 8'hEE, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
    exp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.clr_req = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 4'd4; bus.req_data = 8'h5A;
    step();
    bus.clr_req = 1'b0;
    n_checks++;
    if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL clrpri_ready: ready=%b busy=%b want ready=0 busy=1", bus.req_ready, bus.busy);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (lat_rn !== exp_rn[k] || lat_e !== exp_e[k] || lat_d !== exp_d[k] || bus.done !== exp_done[k])
        $display("FAIL clrpri_c%0d: rn=%h e=%h d=%h done=%b want rn=%h e=%h d=%h done=%b",
                 k, lat_rn, lat_e, lat_d, bus.done, exp_rn[k], exp_e[k], exp_d[k], exp_done[k]);
      else n_pass++;
      if (k == 3) bus.req_valid = 1'b0;
      step();
    end
  endtask

  task automatic test_pending_clear();
    logic [7:0] exp_e  [9];
    logic [7:0] exp_rn [9];
    logic       exp_done [9];
    logic       exp_busy [9];
    exp_e    = '{8'h00, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_rn   = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bus.req_valid = 1'b1; bus.req_addr = 4'd2; bus.req_data = 8'h3C;
    step();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      bus.clr_req = (k == 0 || k == 2);
      n_checks++;
      if (lat_e !== exp_e[k] || lat_rn !== exp_rn[k] || lat_d !== 8'h3C ||
          bus.done !== exp_done[k] || bus.busy !== exp_busy[k])
        $display("FAIL pendclr_c%0d: e=%h rn=%h d=%h done=%b busy=%b want e=%h rn=%h d=3c done=%b busy=%b",
                 k, lat_e, lat_rn, lat_d, bus.done, bus.busy, exp_e[k], exp_rn[k], exp_done[k], exp_busy[k]);
      else n_pass++;
      if (k == 4) begin
        n_checks++;
        if (bus.req_ready !== 1'b0) $display("FAIL pendclr_ready: got %b want 0", bus.req_ready);
        else n_pass++;
      end
      step();
    end
    bus.clr_req = 1'b0;
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL pendclr_idle_ready: got %b want 1", bus.req_ready);
    else n_pass++;
  endtask

  task automatic test_bad_addr();
    logic exp_pulse [5];
    exp_pulse = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.req_valid = 1'b1; bus.req_addr = 4'd9; bus.req_data = 8'h77;
    step();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (lat_e !== 8'h00 || lat_d !== 8'h77 || bus.done !== exp_pulse[k] || bus.err !== exp_pulse[k])
        $display("FAIL badaddr_c%0d: e=%h d=%h done=%b err=%b want e=00 d=77 done=%b err=%b",
                 k, lat_e, lat_d, bus.done, bus.err, exp_pulse[k], exp_pulse[k]);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_async_reset();
    int n_done;
    bus.req_valid = 1'b1; bus.req_addr = 4'd5; bus.req_data = 8'h99;
    step();
    bus.req_valid = 1'b0;
    step();
    n_checks++;
    if (lat_e !== 8'h20) $display("FAIL arst_pulse: e=%h want 20", lat_e);
    else n_pass++;
    #2 RN = 1'b0;
    #1;
    n_checks++;
    if (lat_e !== 8'h00 || lat_rn !== 8'hFF || lat_d !== 8'h00)
      $display("FAIL arst_immediate: e/rn/d=%h/%h/%h want 00/ff/00", lat_e, lat_rn, lat_d);
    else n_pass++;
    n_checks++;
    if ({bus.busy, bus.done, bus.err, bus.req_ready} !== 4'b0001)
      $display("FAIL arst_status: busy/done/err/ready=%b want 0001",
               {bus.busy, bus.done, bus.err, bus.req_ready});
    else n_pass++;
    step();
    RN = 1'b1;
    n_done = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.done === 1'b1 || lat_e !== 8'h00) n_done++;
    end
    n_checks++;
    if (n_done != 0 || bus.req_ready !== 1'b1)
      $display("FAIL arst_after: stray done/enable cycles=%0d ready=%b want 0 and 1", n_done, bus.req_ready);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_clear_priority();
    test_pending_clear();
    test_bad_addr();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
